param_stack: RTL and testbench

//  Parametrised LIFO replacing the fixed 2-bit stack used by the maze solver. Generalises width and depth.

---
 rtl/stack_pkg.sv | 12 +
 rtl/stack_mem.sv | 31 +++
 rtl/param_stack.sv | 110 +++++++++++
 tb/tb_param_stack.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// stack_pkg: shared op encoding and count-width helper for param_stack.
package stack_pkg;
    // Op codes are formed as {push, pop}
    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_PUSH = 2'b10;
    localparam logic [1:0] OP_SWAP = 2'b11;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/stack_mem.sv
// stack_mem: DEPTH x WIDTH register file, one write port, top read port.
// A second (peek) read port exists only when STACK_PEEK_EN is defined.
module stack_mem #(
    parameter  int WIDTH = 2,
    parameter  int DEPTH = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
`ifdef STACK_PEEK_EN
    ,
    input  logic [AW-1:0]    praddr_i,
    output logic [WIDTH-1:0] prdata_o
`endif
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Contents are not reset; the count decides what is meaningful
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];
`ifdef STACK_PEEK_EN
    assign prdata_o = mem_q[praddr_i];
`endif
endmodule

// File: rtl/param_stack.sv
// param_stack: parametrised LIFO with count, error pulses, registered pop output.
// Optional combinational peek port enabled by defining STACK_PEEK_EN.
module param_stack
    import stack_pkg::*;
#(
    parameter  int WIDTH = 2,
    parameter  int DEPTH = 256,
    localparam int CNT_W = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic             underflow,
    input  logic [CNT_W-1:0] peek_idx,
    output logic [WIDTH-1:0] peek_data
);
    localparam int AW = $clog2(DEPTH);

    logic [1:0]       op;
    logic [CNT_W-1:0] count_q, count_d, top_idx;
    logic [WIDTH-1:0] data_q, data_d, top_rdata;
    logic             valid_q, valid_d, ovf_q, ovf_d, unf_q, unf_d;
    logic             pop_ok, we;
    logic [AW-1:0]    waddr, raddr;

    assign op      = {push, pop};
    assign full    = count_q == CNT_W'(DEPTH);
    assign empty   = count_q == '0;
    assign top_idx = count_q - CNT_W'(1);
    assign raddr   = AW'(top_idx);
    // Replace-top overwrites the current top slot; plain push writes above it
    assign waddr   = AW'(op == OP_SWAP ? top_idx : count_q);
    assign we      = !init && ((op == OP_PUSH && !full) || (op == OP_SWAP && !empty));
    assign pop_ok  = !init && ((op == OP_POP && !empty) || op == OP_SWAP);

    always_comb begin
        count_d = init ? '0
                : (op == OP_PUSH && !full) ? count_q + CNT_W'(1)
                : (op == OP_POP && !empty) ? count_q - CNT_W'(1)
                : count_q;
        data_d  = !pop_ok ? data_q : empty ? data_in : top_rdata;
        valid_d = pop_ok;
        ovf_d   = !init && op == OP_PUSH && full;
        unf_d   = !init && op == OP_POP && empty;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign count     = count_q;
    assign data_out  = data_q;
    assign out_valid = valid_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

`ifdef STACK_PEEK_EN
    logic [CNT_W-1:0] peek_pos;
    logic [WIDTH-1:0] peek_rdata;

    assign peek_pos  = top_idx - peek_idx;
    assign peek_data = peek_idx < count_q ? peek_rdata : '0;

    stack_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
        .clk      (clk),
        .we_i     (we),
        .waddr_i  (waddr),
        .wdata_i  (data_in),
        .raddr_i  (raddr),
        .rdata_o  (top_rdata),
        .praddr_i (AW'(peek_pos)),
        .prdata_o (peek_rdata)
    );
`else
    logic unused_peek;

    assign unused_peek = ^peek_idx;
    assign peek_data   = '0;

    stack_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (data_in),
        .raddr_i (raddr),
        .rdata_o (top_rdata)
    );
`endif
endmodule

// File: tb/tb_param_stack.sv
// tb_param_stack: randomized and directed checks of param_stack (DEPTH=4 and DEPTH=256)
// against a queue-based LIFO model. Peek checks follow STACK_PEEK_EN.
module tb_param_stack;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       p4_init = 0, p4_push = 0, p4_pop = 0;
    logic [1:0] p4_din = 0, p4_dout, p4_peek;
    logic       p4_valid, p4_full, p4_empty, p4_ovf, p4_unf;
    logic [2:0] p4_count, p4_pidx = 0;

    logic       b_init = 0, b_push = 0, b_pop = 0;
    logic [1:0] b_din = 0, b_dout, b_peek;
    logic       b_valid, b_full, b_empty, b_ovf, b_unf;
    logic [8:0] b_count, b_pidx = 0;

    param_stack #(.WIDTH(2), .DEPTH(4)) u4 (
        .clk(clk), .rst(rst), .init(p4_init), .push(p4_push), .pop(p4_pop),
        .data_in(p4_din), .data_out(p4_dout), .out_valid(p4_valid), .full(p4_full),
        .empty(p4_empty), .count(p4_count), .overflow(p4_ovf), .underflow(p4_unf),
        .peek_idx(p4_pidx), .peek_data(p4_peek)
    );

    param_stack #(.WIDTH(2), .DEPTH(256)) u256 (
        .clk(clk), .rst(rst), .init(b_init), .push(b_push), .pop(b_pop),
        .data_in(b_din), .data_out(b_dout), .out_valid(b_valid), .full(b_full),
        .empty(b_empty), .count(b_count), .overflow(b_ovf), .underflow(b_unf),
        .peek_idx(b_pidx), .peek_data(b_peek)
    );

    int checks = 0, failures = 0;

    // Reference model for the DEPTH=4 instance
    int         q4[$];
    logic [1:0] e_d = 0;
    bit         e_v, e_o, e_u;

    task automatic op4(input bit pu, input bit po, input bit it, input logic [1:0] d);
        p4_push = pu; p4_pop = po; p4_init = it; p4_din = d;
        @(posedge clk); #1;
        p4_push = 0; p4_pop = 0; p4_init = 0;
        e_v = 0; e_o = 0; e_u = 0;
        if (it) q4.delete();
        else if (pu && po) begin
            e_v = 1;
            if (q4.size() == 0) e_d = d;
            else begin e_d = 2'(q4[$]); q4[q4.size()-1] = d; end
        end else if (pu) begin
            if (q4.size() == 4) e_o = 1; else q4.push_back(d);
        end else if (po) begin
            if (q4.size() == 0) e_u = 1; else begin e_d = 2'(q4.pop_back()); e_v = 1; end
        end
    endtask

    task automatic test_reset;
        #1;
        checks += 5;
        if (p4_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", p4_count); end
        if (p4_empty !== 1'b1 || p4_full !== 1'b0) begin failures++; $display("FAIL reset_flags got e=%b f=%b exp e=1 f=0", p4_empty, p4_full); end
        if (p4_dout !== 2'd0) begin failures++; $display("FAIL reset_dout got=%0d exp=0", p4_dout); end
        if ({p4_valid, p4_ovf, p4_unf} !== 3'b000) begin failures++; $display("FAIL reset_pulses got=%b exp=000", {p4_valid, p4_ovf, p4_unf}); end
        if (b_count !== 9'd0 || b_empty !== 1'b1) begin failures++; $display("FAIL reset_b got c=%0d e=%b exp c=0 e=1", b_count, b_empty); end
        @(negedge clk); rst = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_fill_drain;
        logic [1:0] pat [4] = '{2'd3, 2'd0, 2'd1, 2'd2};
        logic [1:0] exp_pop [4] = '{2'd2, 2'd1, 2'd0, 2'd3};
        for (int i = 0; i < 4; i++) op4(1, 0, 0, pat[i]);
        checks += 2;
        if (p4_full !== 1'b1) begin failures++; $display("FAIL fill_full got=%b exp=1", p4_full); end
        if (p4_count !== 3'd4) begin failures++; $display("FAIL fill_count got=%0d exp=4", p4_count); end
        op4(1, 0, 0, 2'd1);
        checks += 2;
        if (p4_ovf !== 1'b1) begin failures++; $display("FAIL overflow got=%b exp=1", p4_ovf); end
        if (p4_count !== 3'd4) begin failures++; $display("FAIL ovf_count got=%0d exp=4", p4_count); end
        @(posedge clk); #1;
        checks++;
        if (p4_ovf !== 1'b0) begin failures++; $display("FAIL ovf_pulse_width got=%b exp=0", p4_ovf); end
        for (int i = 0; i < 4; i++) begin
            op4(0, 1, 0, 2'd0);
            checks++;
            if (p4_dout !== exp_pop[i] || p4_valid !== 1'b1)
                begin failures++; $display("FAIL drain_%0d got d=%0d v=%b exp d=%0d v=1", i, p4_dout, p4_valid, exp_pop[i]); end
        end
        checks++;
        if (p4_empty !== 1'b1) begin failures++; $display("FAIL drain_empty got=%b exp=1", p4_empty); end
        op4(0, 1, 0, 2'd0);
        checks++;
        if (p4_unf !== 1'b1 || p4_dout !== 2'd3 || p4_valid !== 1'b0)
            begin failures++; $display("FAIL underflow got u=%b d=%0d v=%b exp u=1 d=3 v=0", p4_unf, p4_dout, p4_valid); end
    endtask

    task automatic test_swap;
        op4(1, 0, 0, 2'd1); op4(1, 0, 0, 2'd2);
        op4(1, 1, 0, 2'd3);
        checks++;
        if (p4_dout !== 2'd2 || p4_count !== 3'd2 || p4_valid !== 1'b1)
            begin failures++; $display("FAIL swap got d=%0d c=%0d v=%b exp d=2 c=2 v=1", p4_dout, p4_count, p4_valid); end
        op4(0, 1, 0, 2'd0);
        checks++;
        if (p4_dout !== 2'd3) begin failures++; $display("FAIL swap_pop got=%0d exp=3", p4_dout); end
        op4(0, 1, 0, 2'd0);
        op4(1, 1, 0, 2'd2);
        checks++;
        if (p4_dout !== 2'd2 || p4_valid !== 1'b1 || p4_count !== 3'd0 || p4_ovf !== 1'b0 || p4_unf !== 1'b0)
            begin failures++; $display("FAIL passthru got d=%0d v=%b c=%0d o=%b u=%b exp d=2 v=1 c=0 o=0 u=0", p4_dout, p4_valid, p4_count, p4_ovf, p4_unf); end
    endtask

    task automatic test_init;
        op4(1, 0, 0, 2'd1); op4(1, 0, 0, 2'd0); op4(0, 1, 0, 2'd0);
        op4(1, 1, 1, 2'd3);
        checks++;
        if (p4_count !== 3'd0 || p4_dout !== 2'd0 || {p4_valid, p4_ovf, p4_unf} !== 3'b000)
            begin failures++; $display("FAIL init got c=%0d d=%0d p=%b exp c=0 d=0 p=000", p4_count, p4_dout, {p4_valid, p4_ovf, p4_unf}); end
    endtask

    task automatic test_random;
        int r;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 19);
            op4(r < 9 || r >= 17, (r >= 9 && r < 17) || r >= 17, r == 19 ? 1'b0 : 1'b0, 2'($urandom));
            if (r == 16) op4(0, 0, 1, 2'd0);
            checks++;
            if (p4_count !== 3'(q4.size()) || p4_dout !== e_d || p4_valid !== e_v || p4_ovf !== e_o ||
                p4_unf !== e_u || p4_full !== (q4.size() == 4) || p4_empty !== (q4.size() == 0))
                begin failures++; $display("FAIL random_%0d got c=%0d d=%0d v=%b o=%b u=%b exp c=%0d d=%0d v=%b o=%b u=%b", i, p4_count, p4_dout, p4_valid, p4_ovf, p4_unf, q4.size(), e_d, e_v, e_o, e_u); end
        end
    endtask

    task automatic test_peek;
        op4(0, 0, 1, 2'd0);
        op4(1, 0, 0, 2'd3); op4(1, 0, 0, 2'd0); op4(1, 0, 0, 2'd1);
        for (int i = 0; i < 4; i++) begin
            logic [1:0] exp;
`ifdef STACK_PEEK_EN
            exp = i < q4.size() ? 2'(q4[q4.size()-1-i]) : 2'd0;
`else
            exp = 2'd0;
`endif
            p4_pidx = 3'(i); #1;
            checks++;
            if (p4_peek !== exp) begin failures++; $display("FAIL peek_%0d got=%0d exp=%0d", i, p4_peek, exp); end
        end
        p4_pidx = 0;
    endtask

    task automatic test_deep;
        int bq[$];
        int full_hits = 0;
        for (int i = 0; i < 256; i++) begin
            b_din = i == 255 ? 2'd3 : 2'($urandom); b_push = 1;
            bq.push_back(b_din);
            @(posedge clk); #1; b_push = 0;
            if (b_full === 1'b1) full_hits++;
        end
        checks += 2;
        if (full_hits != 1 || b_full !== 1'b1) begin failures++; $display("FAIL deep_full got hits=%0d f=%b exp hits=1 f=1", full_hits, b_full); end
        if (b_count !== 9'd256) begin failures++; $display("FAIL deep_count got=%0d exp=256", b_count); end
        b_push = 1; b_din = 2'd1; @(posedge clk); #1; b_push = 0;
        checks++;
        if (b_ovf !== 1'b1 || b_count !== 9'd256) begin failures++; $display("FAIL deep_ovf got o=%b c=%0d exp o=1 c=256", b_ovf, b_count); end
        begin
            int bad = 0;
            for (int i = 0; i < 256; i++) begin
                b_pop = 1; @(posedge clk); #1; b_pop = 0;
                if (b_dout !== 2'(bq.pop_back()) || b_valid !== 1'b1) bad++;
            end
            checks += 2;
            if (bad != 0) begin failures++; $display("FAIL deep_drain got bad=%0d exp=0", bad); end
            if (b_empty !== 1'b1) begin failures++; $display("FAIL deep_empty got=%b exp=1", b_empty); end
        end
    endtask

    task automatic test_reset_mid;
        op4(0, 0, 1, 2'd0);
        op4(1, 0, 0, 2'd1); op4(1, 0, 0, 2'd2); op4(1, 0, 0, 2'd3); op4(1, 0, 0, 2'd2);
        op4(0, 1, 0, 2'd0);
        p4_push = 1; p4_din = 2'd1;
        #2 rst = 0; #1;
        checks++;
        if (p4_count !== 3'd0 || p4_empty !== 1'b1 || p4_full !== 1'b0 || p4_dout !== 2'd0 || {p4_valid, p4_ovf, p4_unf} !== 3'b000)
            begin failures++; $display("FAIL reset_mid got c=%0d e=%b f=%b d=%0d p=%b exp c=0 e=1 f=0 d=0 p=000", p4_count, p4_empty, p4_full, p4_dout, {p4_valid, p4_ovf, p4_unf}); end
        @(posedge clk); #1;
        checks++;
        if (p4_count !== 3'd0) begin failures++; $display("FAIL reset_hold got=%0d exp=0", p4_count); end
        p4_push = 0;
        @(negedge clk); rst = 1;
        q4.delete(); e_d = 0;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset;
        test_fill_drain;
        test_swap;
        test_init;
        q4.delete(); e_d = p4_dout;
        test_random;
        test_peek;
        test_deep;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
